// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: SRAM-like instruction port plus the fetch-to-decode handshake.
// The master modport is the fetch stage; the slave modport is the SRAM/decode side.
interface if_fetch_stage_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_ex_adef;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_wdata, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  ds_allowin,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_ex_adef
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_wdata, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output ds_allowin,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_ex_adef
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding SRAM read, hold buffer for decode stalls, redirects.
// Optional macro IF_ADEF_EN: raise fs_ex_adef instead of fetching from a misaligned PC.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  flush,
  input  logic [31:0]           flush_target,
  if_fetch_stage_if.master      bus
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        drop_q, drop_d;
  logic        adef_q, adef_d;

  logic        redirect;
  logic [31:0] target;
  logic        req;
  logic        accepted;
  logic        adef_fault;

  assign redirect = flush | br_taken;
  assign target   = flush ? flush_target : br_target;

`ifdef IF_ADEF_EN
  logic misaligned;
  assign misaligned = (state_q == S_REQ) && (pc_req_q[1:0] != 2'b00);
  assign adef_fault = misaligned & ~redirect & ~rst;
  assign req        = (state_q == S_REQ) & ~rst & ~misaligned;
`else
  assign adef_fault = 1'b0;
  assign req        = (state_q == S_REQ) & ~rst;
`endif

  // A late data_ok seen in S_REQ is never mistaken for an accepted request.
  assign accepted = req & bus.inst_sram_addr_ok;

  assign bus.inst_sram_req   = req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'b10;
  assign bus.inst_sram_wstrb = 4'h0;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.inst_sram_addr  = rst ? RESET_PC : pc_req_q;

  assign bus.fs_pc      = fs_pc_q;
  assign bus.fs_inst    = (state_q == S_WAIT && bus.inst_sram_data_ok) ? bus.inst_sram_rdata
                                                                      : inst_buf_q;
  assign bus.fs_ex_adef = adef_q;
  assign bus.fs_to_ds_valid = ~rst & ~redirect &
      ((state_q == S_HOLD) |
       ((state_q == S_WAIT) & bus.inst_sram_data_ok & ~drop_q));

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d    = state_q;
    pc_req_d   = pc_req_q;
    fs_pc_d    = fs_pc_q;
    inst_buf_d = inst_buf_q;
    drop_d     = drop_q;
    adef_d     = adef_q;
    case (state_q)
      S_REQ: begin
        if (adef_fault) begin
          state_d    = S_HOLD;
          fs_pc_d    = pc_req_q;
          inst_buf_d = 32'h0;
          adef_d     = 1'b1;
        end else if (accepted) begin
          state_d = S_WAIT;
          if (redirect) begin
            drop_d   = 1'b1;
            pc_req_d = target;
          end else begin
            fs_pc_d = pc_req_q;
          end
        end else if (redirect) begin
          pc_req_d = target;
        end
      end
      S_WAIT: begin
        if (bus.inst_sram_data_ok) begin
          if (drop_q | redirect) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
            if (redirect) pc_req_d = target;
          end else if (bus.ds_allowin) begin
            state_d  = S_REQ;
            pc_req_d = fs_pc_q + 32'd4;
          end else begin
            state_d    = S_HOLD;
            inst_buf_d = bus.inst_sram_rdata;
          end
        end else if (redirect) begin
          drop_d   = 1'b1;
          pc_req_d = target;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d    = S_REQ;
          pc_req_d   = target;
          inst_buf_d = 32'h0;
          adef_d     = 1'b0;
        end else if (bus.ds_allowin) begin
          state_d  = S_REQ;
          pc_req_d = fs_pc_q + 32'd4;
          adef_d   = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_req_q   <= RESET_PC;
      fs_pc_q    <= 32'h0;
      inst_buf_q <= 32'h0;
      drop_q     <= 1'b0;
      adef_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_req_q   <= pc_req_d;
      fs_pc_q    <= fs_pc_d;
      inst_buf_q <= inst_buf_d;
      drop_q     <= drop_d;
      adef_q     <= adef_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: fetch, stall/hold, redirects, PC wrap, mid-run reset, adef.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_target;
  int          checks = 0;
  int          errors = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .flush        (flush),
    .flush_target (flush_target),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; flush = 1'b0; flush_target = 32'h0;
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata = 32'h0; bus.ds_allowin = 1'b0;

    // Reset held for three cycles
    tick(); tick(); tick();
    settle();
    check("rst_req",   32'(bus.inst_sram_req), 32'd0);
    check("rst_addr",  bus.inst_sram_addr, 32'h1c000000);
    check("rst_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("rst_adef",  32'(bus.fs_ex_adef), 32'd0);
    check("rst_inst",  bus.fs_inst, 32'h0);
    check("tie_wr",    32'(bus.inst_sram_wr), 32'd0);
    check("tie_size",  32'(bus.inst_sram_size), 32'd2);
    check("tie_wstrb", 32'(bus.inst_sram_wstrb), 32'd0);
    check("tie_wdata", bus.inst_sram_wdata, 32'h0);

    rst = 1'b0;
    settle();
    check("first_req",  32'(bus.inst_sram_req), 32'd1);
    check("first_addr", bus.inst_sram_addr, 32'h1c000000);

    // Straight fetch with decode ready
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata = 32'h02800000; bus.ds_allowin = 1'b1;
    settle();
    check("t2_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("t2_pc",    bus.fs_pc, 32'h1c000000);
    check("t2_inst",  bus.fs_inst, 32'h02800000);
    check("t2_noreq", 32'(bus.inst_sram_req), 32'd0);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    settle();
    check("t2_req",  32'(bus.inst_sram_req), 32'd1);
    check("t2_addr", bus.inst_sram_addr, 32'h1c000004);

    // Decode stalls 5 cycles; buffered instruction must hold
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata = 32'h02800421; bus.ds_allowin = 1'b0;
    settle();
    check("t3_bypass_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("t3_bypass_inst",  bus.fs_inst, 32'h02800421);
    tick();
    bus.inst_sram_data_ok = 1'b0; bus.inst_sram_rdata = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_hold_valid", 32'(bus.fs_to_ds_valid), 32'd1);
      check("t3_hold_inst",  bus.fs_inst, 32'h02800421);
      check("t3_hold_pc",    bus.fs_pc, 32'h1c000004);
      check("t3_hold_noreq", 32'(bus.inst_sram_req), 32'd0);
      tick();
    end
    bus.ds_allowin = 1'b1;
    settle();
    check("t3_accept_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    tick();
    settle();
    check("t3_req",  32'(bus.inst_sram_req), 32'd1);
    check("t3_addr", bus.inst_sram_addr, 32'h1c000008);

    // Branch while waiting: returned data is dropped
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1c000100;
    settle();
    check("t4_br_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    tick();
    br_taken = 1'b0; bus.inst_sram_data_ok = 1'b1; bus.inst_sram_rdata = 32'h11111111;
    settle();
    check("t4_drop_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    settle();
    check("t4_req",  32'(bus.inst_sram_req), 32'd1);
    check("t4_addr", bus.inst_sram_addr, 32'h1c000100);

    // Branch while the request is still pending: address moves
    br_taken = 1'b1; br_target = 32'h1c000200;
    settle();
    check("req_redir_old_addr", bus.inst_sram_addr, 32'h1c000100);
    tick();
    br_taken = 1'b0;
    settle();
    check("req_redir_new_addr", bus.inst_sram_addr, 32'h1c000200);

    // Flush and branch together in S_HOLD: flush wins, nothing delivered
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata = 32'h22222222; bus.ds_allowin = 1'b0;
    tick();
    bus.inst_sram_data_ok = 1'b0;
    flush = 1'b1; flush_target = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000300;
    settle();
    check("t5_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    tick();
    flush = 1'b0; br_taken = 1'b0; bus.ds_allowin = 1'b1;
    settle();
    check("t5_req",  32'(bus.inst_sram_req), 32'd1);
    check("t5_addr", bus.inst_sram_addr, 32'h1c008000);

    // Branch in the same cycle the request is accepted
    bus.inst_sram_addr_ok = 1'b1; br_taken = 1'b1; br_target = 32'h1c000400;
    tick();
    bus.inst_sram_addr_ok = 1'b0; br_taken = 1'b0; bus.inst_sram_data_ok = 1'b1;
    settle();
    check("acc_redir_drop", 32'(bus.fs_to_ds_valid), 32'd0);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    settle();
    check("acc_redir_addr", bus.inst_sram_addr, 32'h1c000400);

    // PC wraps from fffffffc to 0
    br_taken = 1'b1; br_target = 32'hfffffffc;
    tick();
    br_taken = 1'b0;
    settle();
    check("wrap_addr_hi", bus.inst_sram_addr, 32'hfffffffc);
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b1; bus.inst_sram_rdata = 32'h33333333;
    settle();
    check("wrap_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("wrap_pc",    bus.fs_pc, 32'hfffffffc);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    settle();
    check("wrap_addr_zero", bus.inst_sram_addr, 32'h0);

    // Reset mid-transaction, then a late data_ok must be ignored
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0; rst = 1'b1;
    settle();
    check("midrst_req", 32'(bus.inst_sram_req), 32'd0);
    tick();
    rst = 1'b0; bus.inst_sram_data_ok = 1'b1; bus.inst_sram_rdata = 32'h44444444;
    settle();
    check("late_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("late_req",   32'(bus.inst_sram_req), 32'd1);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    settle();
    check("late_still_req", 32'(bus.inst_sram_req), 32'd1);
    check("late_addr",      bus.inst_sram_addr, 32'h1c000000);

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h1c000002;
    tick();
    br_taken = 1'b0; bus.ds_allowin = 1'b0;
    settle();
`ifdef IF_ADEF_EN
    check("adef_noreq", 32'(bus.inst_sram_req), 32'd0);
    tick();
    settle();
    check("adef_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("adef_flag",  32'(bus.fs_ex_adef), 32'd1);
    check("adef_pc",    bus.fs_pc, 32'h1c000002);
    check("adef_inst",  bus.fs_inst, 32'h0);
    tick();
    settle();
    check("adef_hold",  32'(bus.fs_ex_adef), 32'd1);
    br_taken = 1'b1; br_target = 32'h1c000000;
    settle();
    check("adef_redir_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    tick();
    br_taken = 1'b0;
    settle();
    check("adef_clear", 32'(bus.fs_ex_adef), 32'd0);
    check("adef_addr",  bus.inst_sram_addr, 32'h1c000000);
    check("adef_req",   32'(bus.inst_sram_req), 32'd1);
`else
    check("noadef_req",  32'(bus.inst_sram_req), 32'd1);
    check("noadef_addr", bus.inst_sram_addr, 32'h1c000002);
    check("noadef_flag", 32'(bus.fs_ex_adef), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
